reduction_ctrl: RTL and testbench

//  Sequences one tiled FP16 reduction pass: accepts a command, loads the accumulator (zero, bias or keep),

---
 rtl/reduction_pkg.sv | 26 ++
 rtl/reduction_ctrl_if.sv | 42 ++++
 rtl/reduction_ctrl.sv | 97 +++++++++
 tb/tb_reduction_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_pkg.sv
// Shared constants and enums for the tiled FP16 reduction controller.
package reduction_pkg;
  localparam int TILE_SIZE     = 129;
  localparam int PARALLEL_SIZE = 3;
  localparam int WIDTH         = 16;
  localparam int MAX_BEATS     = 256;
  localparam int BEAT_W        = $clog2(MAX_BEATS + 1);
  localparam int VEC_W         = TILE_SIZE * WIDTH;
  localparam int OP_W          = PARALLEL_SIZE * VEC_W;

  localparam logic [WIDTH-1:0] FP16_POS_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } red_state_e;

  // Encoding 3 is reserved and behaves like INIT_ZERO.
  typedef enum logic [1:0] {
    INIT_ZERO = 2'd0,
    INIT_BIAS = 2'd1,
    INIT_KEEP = 2'd2
  } red_init_e;
endpackage

// File: rtl/reduction_ctrl_if.sv
// Bundle of command, operand, datapath, result and perf signals around reduction_ctrl.
interface reduction_ctrl_if;
  import reduction_pkg::*;

  // Every valid/ready pair transfers on a rising clk edge where both are high;
  // valid may rise without waiting for ready, and the payload is held while
  // valid is high and ready is low.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [BEAT_W-1:0] cmd_beats;
  logic [1:0]        cmd_init;
  logic [VEC_W-1:0]  bias;

  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_data;

  logic              red_rst;
  logic [VEC_W-1:0]  red_set;
  logic [OP_W-1:0]   red_op;
  logic [VEC_W-1:0]  red_acc;

  logic              res_valid;
  logic              res_ready;
  logic [VEC_W-1:0]  res_data;

  logic [31:0]       busy_cyc;
  logic [31:0]       stall_cyc;
  red_state_e        state;

  modport master (
    output cmd_valid, cmd_beats, cmd_init, bias, op_valid, op_data, red_acc, res_ready,
    input  cmd_ready, op_ready, red_rst, red_set, red_op, res_valid, res_data,
           busy_cyc, stall_cyc, state
  );

  modport slave (
    input  cmd_valid, cmd_beats, cmd_init, bias, op_valid, op_data, red_acc, res_ready,
    output cmd_ready, op_ready, red_rst, red_set, red_op, res_valid, res_data,
           busy_cyc, stall_cyc, state
  );
endinterface

// File: rtl/reduction_ctrl.sv
// Sequences one tiled FP16 reduction pass: command, accumulator load, operand beats, result.
// Optional perf counters are built when REDUCTION_CTRL_PERF_EN is defined.
module reduction_ctrl
  import reduction_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  reduction_ctrl_if.slave bus
);

  red_state_e        state_q;
  red_state_e        state_n;
  logic [BEAT_W-1:0] beats_q;
  logic [BEAT_W-1:0] count_q;
  logic [VEC_W-1:0]  set_q;
  logic              cmd_hs;
  logic              op_hs;
  logic              last_beat;
  logic              init_keep;
  logic              init_bias;

  assign cmd_hs    = (state_q == IDLE) && bus.cmd_valid;
  assign op_hs     = (state_q == ACCUM) && bus.op_valid;
  assign last_beat = op_hs && (count_q == beats_q - BEAT_W'(1));
  assign init_keep = (bus.cmd_init == INIT_KEEP);
  assign init_bias = (bus.cmd_init == INIT_BIAS);

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          // Keeping the accumulator needs no load cycle.
          if (init_keep) state_n = (bus.cmd_beats == '0) ? DONE : ACCUM;
          else           state_n = LOAD;
        end
      end
      LOAD:    state_n = (beats_q == '0) ? DONE : ACCUM;
      ACCUM:   if (last_beat) state_n = DONE;
      DONE:    if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beats_q <= '0;
      count_q <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_n;
      if (cmd_hs) begin
        beats_q <= bus.cmd_beats;
        set_q   <= init_bias ? bus.bias : {TILE_SIZE{FP16_POS_ZERO}};
      end
      // Held at zero outside ACCUM so every pass starts counting from zero.
      if (state_q != ACCUM) count_q <= '0;
      else if (op_hs)       count_q <= count_q + BEAT_W'(1);
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.op_ready  = (state_q == ACCUM);
  assign bus.red_rst   = (state_q == LOAD);
  assign bus.res_valid = (state_q == DONE);
  assign bus.red_set   = set_q;
  assign bus.res_data  = bus.red_acc;
  assign bus.state     = state_q;

  // Feeding +0.0 during bubbles makes the datapath hold its sum.
  assign bus.red_op = op_hs ? bus.op_data : {(PARALLEL_SIZE * TILE_SIZE){FP16_POS_ZERO}};

`ifdef REDUCTION_CTRL_PERF_EN
  logic [31:0] busy_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if ((state_q != IDLE) && (busy_q != '1))
        busy_q <= busy_q + 32'd1;
      if ((state_q == ACCUM) && !bus.op_valid && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.busy_cyc  = busy_q;
  assign bus.stall_cyc = stall_q;
`else
  assign bus.busy_cyc  = '0;
  assign bus.stall_cyc = '0;
`endif

endmodule

// File: tb/tb_reduction_ctrl.sv
// Self-checking bench for reduction_ctrl with an integer-valued FP16 datapath model.
module tb_reduction_ctrl;
  import reduction_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_assert   = 0;
  int n_fail     = 0;
  int rst_pulses = 0;
  int opr_cycles = 0;

  int model_acc [TILE_SIZE];
  int bias_l    [TILE_SIZE];
  int dp_acc    [TILE_SIZE];

  logic [VEC_W-1:0] exp_q[$];

  reduction_ctrl_if bus();

  reduction_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FP16 helpers (non-negative integers only) ----------------
  function automatic logic [15:0] int_to_fp16(input int n);
    int e;
    int m;
    if (n <= 0) return 16'h0000;
    e = 0;
    for (int i = 0; i < 31; i++) if ((n >> i) != 0) e = i;
    m = (n << 10) >> e;
    return {1'b0, 5'(e + 15), 10'(m)};
  endfunction

  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    if (h[14:10] == 5'd0) return 0;
    e = int'(h[14:10]) - 15;
    if (e < 0) return 0;
    return ((1024 + int'(h[9:0])) << e) >> 10;
  endfunction

  // ---------------- reduction datapath stand-in ----------------
  always @(posedge clk) begin : dp_model
    int s;
    for (int l = 0; l < TILE_SIZE; l++) begin
      if (bus.red_rst) begin
        s = fp16_to_int(bus.red_set[l*WIDTH +: WIDTH]);
      end else begin
        s = dp_acc[l];
        for (int p = 0; p < PARALLEL_SIZE; p++)
          s += fp16_to_int(bus.red_op[(p*TILE_SIZE + l)*WIDTH +: WIDTH]);
      end
      dp_acc[l] <= s;
    end
  end

  always_comb begin
    bus.red_acc = '0;
    for (int l = 0; l < TILE_SIZE; l++)
      bus.red_acc[l*WIDTH +: WIDTH] = int_to_fp16(dp_acc[l]);
  end

  always @(negedge clk) begin
    if (bus.red_rst)  rst_pulses++;
    if (bus.op_ready) opr_cycles++;
  end

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    int bad;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      bad = 0;
      for (int l = TILE_SIZE - 1; l >= 0; l--)
        if (obs[l*WIDTH +: WIDTH] !== exp[l*WIDTH +: WIDTH]) bad = l;
      $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad,
             obs[bad*WIDTH +: WIDTH], exp[bad*WIDTH +: WIDTH]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bias_all(input int v);
    for (int l = 0; l < TILE_SIZE; l++) bias_l[l] = v;
  endtask

  // op_mode 1: every operand lane is 1.0, else random 0..3.
  // gap: bubbles before each beat after the first (-1 random 0..2), capped at max_bub total.
  task automatic run_pass(input string name, input int beats, input int init, input int op_mode,
                          input int gap, input int max_bub, input int hold);
    int               base [TILE_SIZE];
    logic [OP_W-1:0]  beat_q[$];
    logic [OP_W-1:0]  d;
    logic [VEC_W-1:0] exp_v;
    logic [VEC_W-1:0] bias_v;
    int val, b, elapsed, budget, bub_total, bub_rem, g, rst0, opr0, exp_lat;
    logic hs;
    bit keep;

    keep = (init == int'(INIT_KEEP));
    for (int l = 0; l < TILE_SIZE; l++)
      base[l] = (init == int'(INIT_BIAS)) ? bias_l[l] : (keep ? model_acc[l] : 0);
    for (int k = 0; k < beats; k++) begin
      d = '0;
      for (int p = 0; p < PARALLEL_SIZE; p++)
        for (int l = 0; l < TILE_SIZE; l++) begin
          val = (op_mode == 1) ? 1 : int'($urandom_range(0, 3));
          d[(p*TILE_SIZE + l)*WIDTH +: WIDTH] = int_to_fp16(val);
          base[l] += val;
        end
      beat_q.push_back(d);
    end
    for (int l = 0; l < TILE_SIZE; l++) begin
      exp_v[l*WIDTH +: WIDTH]  = int_to_fp16(base[l]);
      bias_v[l*WIDTH +: WIDTH] = int_to_fp16(bias_l[l]);
    end
    exp_q.push_back(exp_v);

    chk({name, "/cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_beats = BEAT_W'(beats);
    bus.cmd_init  = 2'(init);
    bus.bias      = bias_v;
    tick();
    bus.cmd_valid = 1'b0;
    rst0 = rst_pulses;
    opr0 = opr_cycles;

    b = 0; elapsed = 0; bub_total = 0; bub_rem = 0;
    budget = 4 * beats + 40;
    while (!bus.res_valid && elapsed < budget) begin
      if (b < beats) begin
        if (bub_rem > 0) begin
          bus.op_valid = 1'b0;
          bub_rem--;
          bub_total++;
        end else begin
          bus.op_valid = 1'b1;
          bus.op_data  = beat_q[b];
        end
      end else begin
        bus.op_valid = 1'b0;
      end
      #1;
      if (!keep && elapsed == 0) begin
        chk({name, "/load_red_rst"}, 32'(bus.red_rst), 32'd1);
        chk({name, "/load_op_ready"}, 32'(bus.op_ready), 32'd0);
        chk({name, "/load_red_op_zero"}, 32'(bus.red_op == '0), 32'd1);
      end
      if (!keep && elapsed == 1) chk({name, "/red_rst_one_cycle"}, 32'(bus.red_rst), 32'd0);
      if (!bus.op_valid) chk({name, "/bubble_red_op_zero"}, 32'(bus.red_op == '0), 32'd1);
      hs = bus.op_valid && bus.op_ready;
      tick();
      elapsed++;
      if (hs) begin
        b++;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        if (bub_total + g > max_bub) g = max_bub - bub_total;
        bub_rem = (b < beats) ? g : 0;
      end
    end
    bus.op_valid = 1'b0;

    exp_lat = (keep ? 0 : 1) + beats + bub_total;
    chk({name, "/res_valid"}, 32'(bus.res_valid), 32'd1);
    chk({name, "/latency"}, 32'(elapsed), 32'(exp_lat));
    chk({name, "/red_rst_pulses"}, 32'(rst_pulses - rst0), keep ? 32'd0 : 32'd1);
    chk({name, "/op_ready_cycles"}, 32'(opr_cycles - opr0), 32'(beats + bub_total));

    for (int i = 0; i < hold; i++) begin
      chk_vec({name, "/held_data"}, bus.res_data, exp_q[0]);
      chk({name, "/held_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      chk({name, "/held_op_ready"}, 32'(bus.op_ready), 32'd0);
      chk({name, "/held_res_valid"}, 32'(bus.res_valid), 32'd1);
      tick();
    end

    // A command offered in the result hand-off cycle must not be taken.
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    #1;
    chk_vec({name, "/result"}, bus.res_data, exp_q.pop_front());
    chk({name, "/done_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk({name, "/back_idle_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({name, "/back_idle_res_valid"}, 32'(bus.res_valid), 32'd0);

    for (int l = 0; l < TILE_SIZE; l++) model_acc[l] = base[l];
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_beats = '0;
    bus.cmd_init  = 2'd0;
    bus.bias      = '0;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.res_ready = 1'b0;
    set_bias_all(0);
    for (int l = 0; l < TILE_SIZE; l++) model_acc[l] = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset/state", 32'(bus.state), 32'(IDLE));
    chk("reset/cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset/op_ready", 32'(bus.op_ready), 32'd0);
    chk("reset/red_rst", 32'(bus.red_rst), 32'd0);
    chk("reset/res_valid", 32'(bus.res_valid), 32'd0);
    chk("reset/red_set_zero", 32'(bus.red_set == '0), 32'd1);
    chk("reset/busy_cyc", bus.busy_cyc, 32'd0);
    chk("reset/stall_cyc", bus.stall_cyc, 32'd0);

    // T1: zero init, three back-to-back beats of all-ones.
    run_pass("t1", 3, int'(INIT_ZERO), 1, 0, 0, 0);
    // T2: bias 1.0, two beats with a bubble between them.
    set_bias_all(1);
    run_pass("t2", 2, int'(INIT_BIAS), 1, 1, 1, 0);
    // T3: empty passes with bias then keep.
    set_bias_all(2);
    run_pass("t3_bias", 0, int'(INIT_BIAS), 1, 0, 0, 0);
    run_pass("t3_keep", 0, int'(INIT_KEEP), 1, 0, 0, 0);
    // T4: result held back for five cycles.
    for (int l = 0; l < TILE_SIZE; l++) bias_l[l] = int'($urandom_range(0, 7));
    run_pass("t4", 3, int'(INIT_BIAS), 0, -1, 100, 5);

    // T5: reset in the middle of ACCUM.
    bus.cmd_valid = 1'b1;
    bus.cmd_beats = BEAT_W'(4);
    bus.cmd_init  = 2'(INIT_ZERO);
    tick();
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_data   = '0;
    tick();
    chk("t5/op_ready_accum", 32'(bus.op_ready), 32'd1);
    tick();
    bus.op_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5/state_idle", 32'(bus.state), 32'(IDLE));
    chk("t5/cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t5/res_valid", 32'(bus.res_valid), 32'd0);
    chk("t5/op_ready", 32'(bus.op_ready), 32'd0);
    chk("t5/busy_cleared", bus.busy_cyc, 32'd0);

    // T6: four beats, two bubbles, result held one extra cycle.
    run_pass("t6", 4, int'(INIT_ZERO), 1, 1, 2, 1);
`ifdef REDUCTION_CTRL_PERF_EN
    chk("t6/stall_cyc", bus.stall_cyc, 32'd2);
    chk("t6/busy_cyc", bus.busy_cyc, 32'd9);
`else
    chk("t6/stall_cyc", bus.stall_cyc, 32'd0);
    chk("t6/busy_cyc", bus.busy_cyc, 32'd0);
`endif

    // Randomized passes, including reserved init code 3 and keep chains.
    for (int k = 0; k < 20; k++) begin
      for (int l = 0; l < TILE_SIZE; l++) bias_l[l] = int'($urandom_range(0, 7));
      run_pass("rand", int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0, -1, 100,
               int'($urandom_range(0, 2)));
    end

    // Largest legal beat count.
    run_pass("max_beats", MAX_BEATS, int'(INIT_ZERO), 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
